sobel_window_gen: RTL
=====================

Name: sobel_window_gen

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel compute stage.
- Accepts one 8-bit greyscale pixel per handshake in raster order and emits one 3x3 window per image pixel, centred on that pixel.
- Pixels outside the image are zero, giving zero padding on all four borders.
- Replaces whole-image preloading with a bounded ring buffer so the Sobel stage can run on a pixel stream.

Parameters:
- IMAGE_WIDTH_E, 9, log2 of image width.
- IMAGE_HIGHT_E, 9, log2 of image height.
- IMAGE_WIDTH, 2**IMAGE_WIDTH_E, pixels per line (derived).
- IMAGE_HIGHT, 2**IMAGE_HIGHT_E, lines per frame (derived).
- BYTE_SIZE, 8, pixel width in bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block can accept a pixel this cycle.
- s_data  in  BYTE_SIZE  input pixel, raster order, frame after frame.
- m_valid  out  1  output window valid.
- m_ready  in  1  downstream accepts the window.
- m_win  out  9*BYTE_SIZE  window. [71:64]=top-left, [63:56]=top-centre, [55:48]=top-right, then middle row, then bottom row; [7:0]=bottom-right.
- m_first  out  1  qualifies the window for centre (0,0).
- m_last  out  1  qualifies the window for centre (H-1,W-1).

Behaviour:
- Reset (asynchronous): state=FILL, all counters=0, m_valid=0, m_first=0, m_last=0, m_win=0. Ring contents do not need clearing.
- Transfers: a pixel transfers when s_valid&&s_ready; a window transfers when m_valid&&m_ready.
- Linear index: n = r*W + c.
- Latency:
  - Window for centre index k is emitted once input index k+W+1 has been accepted.
  - m_valid rises on the clock edge that accepts input index k+W+1.
  - In FLUSH, the window is emitted with no input.
- Storage: ring of 2*W+3 pixels holding linear indices k-W-1 .. k+W+1 around the current centre.
- States:
  - FILL: s_ready=1, no output. Accepts inputs 0..W. Moves to STREAM after accepting input index W (W+1 pixels).
  - STREAM: s_ready = !m_valid || m_ready. Each accepted input registers exactly one window (centre = input index - W - 1). After accepting input index W*H-1, moves to FLUSH.
  - FLUSH: s_ready=0. Emits the remaining W+1 windows, one per output transfer. The bottom row is zero for centres on the last line. After the window with m_last transfers, moves to FILL for the next frame.
- Padding uses the centre row/column counters (cr, cc):
  - cr==0: top row = 0.
  - cr==H-1: bottom row = 0.
  - cc==0: left column = 0.
  - cc==W-1: right column = 0.
  - Corners combine both rules.
  - No wrap-around: column W-1 never borrows from column 0 of the next line.
- Backpressure: m_win, m_valid, m_first, m_last hold stable while m_valid && !m_ready. No input is accepted unless the output register is free or being drained that cycle.
- Simultaneous events: in STREAM, output transfer and input transfer in the same cycle is allowed and sustains 1 window/cycle.
- Counters: cc and cr wrap at W-1 and H-1; the input counter is IMAGE_WIDTH_E+IMAGE_HIGHT_E bits wide.
- Frame totals: exactly W*H windows out per W*H pixels in; m_first and m_last each asserted exactly once per frame.
- Reset mid-frame: the partial frame is discarded; the next pixel after reset is treated as (0,0).
- s_data is ignored when s_ready=0.

Decomposition:
- Shared package sobel_pkg:
  - BYTE_SIZE.
  - The FILL/STREAM/FLUSH state encoding (2-bit).
  - Window-slot index constants for the nine positions in m_win.
  - A helper for W*H.
- One sub-module: sobel_ring_buf, a parameterised 2*W+3 entry single-write ring with three row taps at offsets 0, W+1 and 2W+2.

Test Plan (IMAGE_WIDTH_E=2, IMAGE_HIGHT_E=2, 4x4 image, s_data = index+1, i.e. 1..16):
- Fill: stream pixels with m_ready=1 -> no m_valid during the first 5 inputs. m_valid rises on the edge accepting the 6th input, with m_first=1 and window 0,0,0 / 0,1,2 / 0,5,6.
- Interior and right border:
  - centre (1,1) gives window 1,2,3 / 5,6,7 / 9,10,11.
  - centre (1,3) gives window 3,4,0 / 7,8,0 / 11,12,0, which checks no wrap into column 0.
- Flush: after input 16, s_ready=0. Five further windows are emitted, the last being 11,12,0 / 15,16,0 / 0,0,0 with m_last=1. The total is 16 windows.
- Backpressure: hold m_ready=0 for 4 cycles mid-STREAM -> m_win stable, s_ready=0, no pixel lost. Output sequence identical to the unstalled run.
- Back-to-back frames: send two frames with the second using values 101..116 -> second frame's first window is 0,0,0 / 0,101,102 / 0,105,106, with no stale data from frame 1.
- Reset mid-frame: assert reset after 9 inputs -> m_valid=0 immediately. A fresh frame then produces the correct 16 windows starting from the m_first window.

Source files
------------

// File: rtl/sobel_window_gen_pkg.sv
// Shared definitions for the Sobel 3x3 window generator.
//   BYTE_SIZE      pixel width in bits
//   sobel_state_e  FILL / STREAM / FLUSH sequencing states
//   SLOT_*         byte-slot index of each window position inside m_win
//                  (slot 8 = [71:64] top-left ... slot 0 = [7:0] bottom-right)
//   frame_size()   pixels per frame, W*H
package sobel_pkg;

    localparam int BYTE_SIZE = 8;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } sobel_state_e;

    localparam int SLOT_TL = 8;
    localparam int SLOT_TC = 7;
    localparam int SLOT_TR = 6;
    localparam int SLOT_ML = 5;
    localparam int SLOT_MC = 4;
    localparam int SLOT_MR = 3;
    localparam int SLOT_BL = 2;
    localparam int SLOT_BC = 1;
    localparam int SLOT_BR = 0;

    function automatic int frame_size(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle for sobel_window_gen.
//   s_valid, s_ready, s_data           pixel stream into the generator
//   m_valid, m_ready, m_win            3x3 window stream out of the generator
//   m_first, m_last                    frame start / end qualifiers on m_win
// slave  : generator side
// master : environment side (pixel source + window sink)
interface sobel_window_gen_if;
    import sobel_pkg::*;

    logic                     s_valid;
    logic                     s_ready;
    logic [BYTE_SIZE-1:0]     s_data;
    logic                     m_valid;
    logic                     m_ready;
    logic [9*BYTE_SIZE-1:0]   m_win;
    logic                     m_first;
    logic                     m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_win, m_first, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_win, m_first, m_last
    );

endinterface

// File: rtl/sobel_window_gen_ring_buf.sv
// Line ring for the window generator: 2*W+3 entries, one write per push.
// Ages are counted from the pixel being pushed this cycle (age 0 = wr_data,
// age 1 = most recently stored). Taps are anchored at ages 0, W+1 and 2W+2,
// i.e. bottom-right, centre and top-left of the window being formed.
//   clk, reset  clock, async active-high reset (pointer only)
//   we          push wr_data
//   wr_data     pixel being pushed
//   tap_top     {left, centre, right} of the top row    (ages 2W+2, 2W+1, 2W)
//   tap_mid     {left, centre, right} of the middle row (ages W+2, W+1, W)
//   tap_bot     {left, centre, right} of the bottom row (ages 2, 1, 0)
module sobel_ring_buf
    import sobel_pkg::*;
#(
    parameter int IMAGE_WIDTH = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [BYTE_SIZE-1:0]     wr_data,
    output logic [3*BYTE_SIZE-1:0]   tap_top,
    output logic [3*BYTE_SIZE-1:0]   tap_mid,
    output logic [3*BYTE_SIZE-1:0]   tap_bot
);

    localparam int DEPTH = 2 * IMAGE_WIDTH + 3;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [BYTE_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;

    // wr_ptr is the slot about to be written, so age a lives at wr_ptr - a
    // (mod DEPTH). DEPTH is not a power of two, hence the explicit wrap.
    function automatic logic [PTR_W-1:0] age_addr(input logic [PTR_W-1:0] ptr,
                                                  input int age);
        logic [PTR_W-1:0] a;
        a = PTR_W'(age);
        if (ptr >= a) return ptr - a;
        return ptr + (DEPTH_P - a);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (we) begin
            wr_ptr <= (wr_ptr == DEPTH_P - 1'b1) ? '0 : wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= wr_data;
    end

    assign tap_bot = {mem[age_addr(wr_ptr, 2)], mem[age_addr(wr_ptr, 1)], wr_data};
    assign tap_mid = {mem[age_addr(wr_ptr, IMAGE_WIDTH + 2)],
                      mem[age_addr(wr_ptr, IMAGE_WIDTH + 1)],
                      mem[age_addr(wr_ptr, IMAGE_WIDTH)]};
    assign tap_top = {mem[age_addr(wr_ptr, 2 * IMAGE_WIDTH + 2)],
                      mem[age_addr(wr_ptr, 2 * IMAGE_WIDTH + 1)],
                      mem[age_addr(wr_ptr, 2 * IMAGE_WIDTH)]};

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel stage. Takes one
// pixel per handshake in raster order and emits one zero-padded window per
// image pixel, centred on that pixel, W+1 pixels behind the input.
//   clk, reset  clock, async active-high reset
//   bus         sobel_window_gen_if.slave (pixel in, window out)
//
// state  | meaning
// FILL   | accept pixels 0..W into the ring, no windows yet
// STREAM | every accepted pixel registers one window (centre = index-W-1)
// FLUSH  | no input; emit the last W+1 windows, then back to FILL
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMAGE_WIDTH_E = 9,
    parameter int IMAGE_HIGHT_E = 9
) (
    input  logic               clk,
    input  logic               reset,
    sobel_window_gen_if.slave  bus
);

    localparam int IMAGE_WIDTH = 2 ** IMAGE_WIDTH_E;
    localparam int IMAGE_HIGHT = 2 ** IMAGE_HIGHT_E;
    localparam int CNT_W       = IMAGE_WIDTH_E + IMAGE_HIGHT_E;
    localparam int B           = BYTE_SIZE;

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(IMAGE_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(frame_size(IMAGE_WIDTH, IMAGE_HIGHT) - 1);
    localparam logic [IMAGE_WIDTH_E-1:0] LAST_COL = '1;
    localparam logic [IMAGE_HIGHT_E-1:0] LAST_ROW = '1;

    sobel_state_e state, next_state;

    logic [CNT_W-1:0]         in_cnt;
    logic [IMAGE_WIDTH_E-1:0] cc;
    logic [IMAGE_HIGHT_E-1:0] cr;

    logic           s_ready_c, take_in, gen, push;
    logic [B-1:0]   wr_data;
    logic [3*B-1:0] tap_top, tap_mid, tap_bot;
    logic [3*B-1:0] row_top, row_mid, row_bot;
    logic [9*B-1:0] win_c;

    logic           m_valid_q, m_first_q, m_last_q;
    logic [9*B-1:0] m_win_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_FILL;
        else       state <= next_state;
    end

    // In FLUSH a zero pixel is pushed per window so the ring taps keep the
    // same age relationship to the centre as in STREAM.
    always_comb begin
        next_state = state;
        s_ready_c  = 1'b0;
        take_in    = 1'b0;
        gen        = 1'b0;
        wr_data    = '0;
        case (state)
            ST_FILL: begin
                s_ready_c = 1'b1;
                take_in   = bus.s_valid;
                wr_data   = bus.s_data;
                if (take_in && in_cnt == FILL_LAST) next_state = ST_STREAM;
            end
            ST_STREAM: begin
                s_ready_c = !m_valid_q || bus.m_ready;
                take_in   = bus.s_valid && s_ready_c;
                gen       = take_in;
                wr_data   = bus.s_data;
                if (take_in && in_cnt == LAST_IN) next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Stop generating once the m_last window is parked in the register.
                gen = !m_valid_q || (bus.m_ready && !m_last_q);
                if (m_valid_q && m_last_q && bus.m_ready) next_state = ST_FILL;
            end
            default: next_state = ST_FILL;
        endcase
    end

    assign push = take_in || gen;

    sobel_ring_buf #(.IMAGE_WIDTH(IMAGE_WIDTH)) u_ring (
        .clk     (clk),
        .reset   (reset),
        .we      (push),
        .wr_data (wr_data),
        .tap_top (tap_top),
        .tap_mid (tap_mid),
        .tap_bot (tap_bot)
    );

    // Border zeroing from the centre coordinates; this also masks stale ring
    // contents from a previous frame or from before a reset.
    always_comb begin
        row_top = (cr == '0)      ? '0 : tap_top;
        row_mid = tap_mid;
        row_bot = (cr == LAST_ROW) ? '0 : tap_bot;
        if (cc == '0) begin
            row_top[2*B +: B] = '0;
            row_mid[2*B +: B] = '0;
            row_bot[2*B +: B] = '0;
        end
        if (cc == LAST_COL) begin
            row_top[0 +: B] = '0;
            row_mid[0 +: B] = '0;
            row_bot[0 +: B] = '0;
        end
        win_c = '0;
        win_c[SLOT_TL*B +: B] = row_top[2*B +: B];
        win_c[SLOT_TC*B +: B] = row_top[1*B +: B];
        win_c[SLOT_TR*B +: B] = row_top[0*B +: B];
        win_c[SLOT_ML*B +: B] = row_mid[2*B +: B];
        win_c[SLOT_MC*B +: B] = row_mid[1*B +: B];
        win_c[SLOT_MR*B +: B] = row_mid[0*B +: B];
        win_c[SLOT_BL*B +: B] = row_bot[2*B +: B];
        win_c[SLOT_BC*B +: B] = row_bot[1*B +: B];
        win_c[SLOT_BR*B +: B] = row_bot[0*B +: B];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt <= '0;
            cc     <= '0;
            cr     <= '0;
        end else begin
            if (take_in) in_cnt <= in_cnt + 1'b1;
            if (gen) begin
                cc <= cc + 1'b1;
                if (cc == LAST_COL) cr <= cr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_win_q   <= '0;
        end else if (gen) begin
            m_valid_q <= 1'b1;
            m_first_q <= (cr == '0) && (cc == '0);
            m_last_q  <= (cr == LAST_ROW) && (cc == LAST_COL);
            m_win_q   <= win_c;
        end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_first = m_first_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_win   = m_win_q;

endmodule
